// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is purely combinational; updates, invalidation and perf counters commit on clk.
module branch_predictor #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CNT_W   = 2
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [DATA_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [DATA_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic              upd_jump,
    input  logic [DATA_W-1:0] upd_target,
    input  logic              upd_mispredict,
    input  logic              inv_all,
    output logic [31:0]       cnt_updates,
    output logic [31:0]       cnt_mispredicts
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntWt  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CntWnt = CNT_W'((1 << (CNT_W - 1)) - 1);

    logic              valid_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [CNT_W-1:0]  cnt_q   [ENTRIES];
    logic [DATA_W-1:0] tgt_q   [ENTRIES];

    logic [31:0] upd_cnt_q, upd_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    // Bits outside index/tag fields carry no information for the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc, upd_pc};

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];

    always_comb begin
        pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = pred_hit && cnt_q[lk_idx][CNT_W-1];
        pred_target = pred_taken ? tgt_q[lk_idx] : lookup_pc + DATA_W'(4);
    end

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [CNT_W-1:0] up_cnt;
    logic             ent_wr;
    logic             tgt_wr;
    logic [CNT_W-1:0] cnt_d;

    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_cnt = cnt_q[up_idx];

    always_comb begin
        ent_wr = 1'b0;
        tgt_wr = 1'b0;
        cnt_d  = up_cnt;
        // A same-cycle invalidate wins over the table write.
        if (en && upd_valid && !inv_all) begin
            if (up_hit) begin
                ent_wr = 1'b1;
                tgt_wr = upd_taken || upd_jump;
                if (upd_jump) begin
                    cnt_d = CntMax;
                end else if (upd_taken) begin
                    cnt_d = (up_cnt == CntMax) ? up_cnt : up_cnt + CNT_W'(1);
                end else begin
                    cnt_d = (up_cnt == '0) ? up_cnt : up_cnt - CNT_W'(1);
                end
            end else if (upd_taken || upd_jump) begin
                ent_wr = 1'b1;
                tgt_wr = 1'b1;
                cnt_d  = upd_jump ? CntMax : CntWt;
            end
        end
    end

    always_comb begin
        upd_cnt_d = upd_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (en && upd_valid) begin
            upd_cnt_d = upd_cnt_q + 32'd1;
            if (upd_mispredict) begin
                mis_cnt_d = mis_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                cnt_q[i]   <= CntWnt;
                tgt_q[i]   <= '0;
            end
        end else if (en && inv_all) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (ent_wr) begin
            valid_q[up_idx] <= 1'b1;
            tag_q[up_idx]   <= up_tag;
            cnt_q[up_idx]   <= cnt_d;
            if (tgt_wr) begin
                tgt_q[up_idx] <= upd_target;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            upd_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            upd_cnt_q <= upd_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign cnt_updates     = upd_cnt_q;
    assign cnt_mispredicts = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor: each row drives one cycle and checks the
// prediction made from the table state before that cycle's update commits.
module tb_branch_predictor;

    localparam int unsigned DATA_W = 64;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              en;
    logic [DATA_W-1:0] lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [DATA_W-1:0] pred_target;
    logic              upd_valid;
    logic [DATA_W-1:0] upd_pc;
    logic              upd_taken;
    logic              upd_jump;
    logic [DATA_W-1:0] upd_target;
    logic              upd_mispredict;
    logic              inv_all;
    logic [31:0]       cnt_updates;
    logic [31:0]       cnt_mispredicts;

    branch_predictor #(
        .DATA_W (DATA_W),
        .ENTRIES(16),
        .TAG_W  (8),
        .CNT_W  (2)
    ) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .en             (en),
        .lookup_pc      (lookup_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_jump       (upd_jump),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .inv_all        (inv_all),
        .cnt_updates    (cnt_updates),
        .cnt_mispredicts(cnt_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        uv;
        logic [63:0] upc;
        logic        ut;
        logic        uj;
        logic [63:0] utgt;
        logic        umis;
        logic        inv;
        logic [63:0] lpc;
        logic        eh;
        logic        et;
        logic [63:0] etgt;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    int checks   = 0;
    int failures = 0;
    int exp_upd  = 0;
    int exp_mis  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic e, input logic uv, input logic [63:0] upc,
                                input logic ut, input logic uj, input logic [63:0] utgt,
                                input logic umis, input logic inv, input logic [63:0] lpc,
                                input logic eh, input logic et, input logic [63:0] etgt);
        vec_t v;
        v.en = e; v.uv = uv; v.upc = upc; v.ut = ut; v.uj = uj; v.utgt = utgt;
        v.umis = umis; v.inv = inv; v.lpc = lpc; v.eh = eh; v.et = et; v.etgt = etgt;
        return v;
    endfunction

    task automatic idle_inputs();
        en = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_jump = 1'b0;
        upd_target = '0; upd_mispredict = 1'b0; inv_all = 1'b0; lookup_pc = 64'h100;
    endtask

    initial begin
        //            en uv upc     ut uj utgt    mis inv lpc     hit tk target
        vecs[0]  = mk(1, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h100, 0, 0, 64'h104);
        vecs[1]  = mk(1, 1, 64'h100, 1, 0, 64'h200, 0, 0, 64'h100, 0, 0, 64'h104);
        vecs[2]  = mk(1, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h100, 1, 1, 64'h200);
        vecs[3]  = mk(1, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h140, 0, 0, 64'h144);
        vecs[4]  = mk(1, 1, 64'h100, 0, 0, 64'h0,   0, 0, 64'h100, 1, 1, 64'h200);
        vecs[5]  = mk(1, 1, 64'h100, 0, 0, 64'h0,   1, 0, 64'h100, 1, 0, 64'h104);
        vecs[6]  = mk(1, 1, 64'h100, 1, 0, 64'h200, 0, 0, 64'h100, 1, 0, 64'h104);
        vecs[7]  = mk(1, 1, 64'h100, 1, 0, 64'h200, 0, 0, 64'h100, 1, 0, 64'h104);
        vecs[8]  = mk(1, 1, 64'h100, 1, 0, 64'h200, 0, 0, 64'h100, 1, 1, 64'h200);
        vecs[9]  = mk(1, 1, 64'h100, 1, 0, 64'h208, 0, 0, 64'h100, 1, 1, 64'h200);
        vecs[10] = mk(1, 1, 64'h100, 0, 0, 64'h0,   0, 0, 64'h100, 1, 1, 64'h208);
        vecs[11] = mk(1, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h100, 1, 1, 64'h208);
        vecs[12] = mk(1, 1, 64'h80,  0, 1, 64'h400, 0, 0, 64'h80,  0, 0, 64'h84);
        vecs[13] = mk(1, 1, 64'h80,  0, 0, 64'h0,   1, 0, 64'h80,  1, 1, 64'h400);
        vecs[14] = mk(1, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h80,  1, 1, 64'h400);
        vecs[15] = mk(1, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h100, 0, 0, 64'h104);
        vecs[16] = mk(1, 1, 64'h44,  0, 0, 64'h900, 0, 0, 64'h44,  0, 0, 64'h48);
        vecs[17] = mk(1, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h44,  0, 0, 64'h48);
        vecs[18] = mk(0, 1, 64'h44,  1, 0, 64'h500, 1, 0, 64'h44,  0, 0, 64'h48);
        vecs[19] = mk(1, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h44,  0, 0, 64'h48);
        vecs[20] = mk(1, 1, 64'h44,  1, 0, 64'h500, 0, 0, 64'h44,  0, 0, 64'h48);
        vecs[21] = mk(1, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h44,  1, 1, 64'h500);
        vecs[22] = mk(1, 1, 64'h80,  1, 0, 64'h600, 1, 1, 64'h80,  1, 1, 64'h400);
        vecs[23] = mk(1, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h80,  0, 0, 64'h84);
        vecs[24] = mk(1, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h44,  0, 0, 64'h48);
        vecs[25] = mk(1, 0, 64'h44,  1, 1, 64'h700, 1, 0, 64'h44,  0, 0, 64'h48);
        vecs[26] = mk(1, 0, 64'h0,   0, 0, 64'h0,   0, 0, 64'h44,  0, 0, 64'h48);

        idle_inputs();
        arst_n = 1'b0;
        #1;
        check("rst_hit", {63'd0, pred_hit}, 64'd0);
        check("rst_taken", {63'd0, pred_taken}, 64'd0);
        check("rst_target", pred_target, 64'h104);
        check("rst_cnt_upd", {32'd0, cnt_updates}, 64'd0);
        check("rst_cnt_mis", {32'd0, cnt_mispredicts}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            en = vecs[i].en; upd_valid = vecs[i].uv; upd_pc = vecs[i].upc;
            upd_taken = vecs[i].ut; upd_jump = vecs[i].uj; upd_target = vecs[i].utgt;
            upd_mispredict = vecs[i].umis; inv_all = vecs[i].inv; lookup_pc = vecs[i].lpc;
            #1;
            check($sformatf("v%0d_hit", i), {63'd0, pred_hit}, {63'd0, vecs[i].eh});
            check($sformatf("v%0d_taken", i), {63'd0, pred_taken}, {63'd0, vecs[i].et});
            check($sformatf("v%0d_target", i), pred_target, vecs[i].etgt);
            check($sformatf("v%0d_cnt_upd", i), {32'd0, cnt_updates}, 64'(exp_upd));
            check($sformatf("v%0d_cnt_mis", i), {32'd0, cnt_mispredicts}, 64'(exp_mis));
            if (vecs[i].en && vecs[i].uv) begin
                exp_upd++;
                if (vecs[i].umis) exp_mis++;
            end
        end

        // Mispredict counter wrap: preload to all-ones while disabled, then one more.
        @(negedge clk);
        idle_inputs();
        en = 1'b0;
        force dut.mis_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.mis_cnt_q;
        @(posedge clk);
        #1;
        check("wrap_preload", {32'd0, cnt_mispredicts}, 64'hFFFF_FFFF);
        @(negedge clk);
        en = 1'b1; upd_valid = 1'b1; upd_mispredict = 1'b1; upd_pc = 64'h44;
        @(posedge clk);
        #1;
        check("wrap_mis", {32'd0, cnt_mispredicts}, 64'd0);
        check("wrap_upd", {32'd0, cnt_updates}, 64'(exp_upd + 1));

        // Reset mid-cycle aborts an allocating update to 0x84.
        @(negedge clk);
        idle_inputs();
        upd_valid = 1'b1; upd_pc = 64'h84; upd_taken = 1'b1; upd_target = 64'hA00;
        lookup_pc = 64'h84;
        #2;
        arst_n = 1'b0;
        #1;
        check("midrst_cnt_upd", {32'd0, cnt_updates}, 64'd0);
        check("midrst_hit", {63'd0, pred_hit}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        arst_n = 1'b1;
        #1;
        check("postrst_hit", {63'd0, pred_hit}, 64'd0);
        check("postrst_target", pred_target, 64'h88);
        check("postrst_cnt_mis", {32'd0, cnt_mispredicts}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter DATA_W, default 64, PC and target width.
REQ-002 SHALL have parameter ENTRIES, default 16, table depth; power of two, 2..256; IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter TAG_W, default 8, tag bits stored per entry; IDX_W+2+TAG_W <= DATA_W.
REQ-004 SHALL have parameter CNT_W, default 2, saturating counter width, 1..4.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port arst_n, input, 1, reset; asynchronous assert, active-low.
REQ-007 SHALL have port en, input, 1, global enable; 0 blocks every state change except reset.
REQ-008 SHALL have port lookup_pc, input, DATA_W, fetch PC to predict.
REQ-009 SHALL have port pred_hit, output, 1, valid tag-matching entry for lookup_pc.
REQ-010 SHALL have port pred_taken, output, 1, predicted taken.
REQ-011 SHALL have port pred_target, output, DATA_W, predicted next PC.
REQ-012 SHALL have port upd_valid, input, 1, resolved-branch update strobe.
REQ-013 SHALL have port upd_pc, input, DATA_W, PC of resolved branch/jump.
REQ-014 SHALL have port upd_taken, input, 1, actual outcome.
REQ-015 SHALL have port upd_jump, input, 1, unconditional jump; implies taken.
REQ-016 SHALL have port upd_target, input, DATA_W, resolved target.
REQ-017 SHALL have port upd_mispredict, input, 1, previous prediction was wrong; qualified by upd_valid.
REQ-018 SHALL have port inv_all, input, 1, invalidate every entry.
REQ-019 SHALL have ports cnt_updates and cnt_mispredicts, output, 32 each, performance counters.

Function
REQ-020 SHALL compute index = pc[IDX_W+1:2] and tag = pc[IDX_W+TAG_W+1:IDX_W+2] for both lookup_pc and upd_pc.
REQ-021 SHALL store per entry: valid, tag, counter (CNT_W), target (DATA_W).
REQ-022 SHALL produce pred_* combinationally from lookup_pc and current table state (zero-cycle latency).
REQ-023 SHALL drive pred_hit = valid & tag match; pred_taken = pred_hit & counter MSB.
REQ-024 SHALL drive pred_target = stored target if pred_taken, else lookup_pc + 4, modulo 2^DATA_W.
REQ-025 SHALL, on upd_valid & en with hit and upd_jump=0: increment counter if upd_taken, else decrement; saturate at all-ones and zero.
REQ-026 SHALL, on hit with upd_jump=1: force counter to all-ones.
REQ-027 SHALL, on hit with taken or jump: overwrite target with upd_target; not-taken leaves target unchanged.
REQ-028 SHALL, on miss with taken or jump: allocate (replace) the indexed entry: valid=1, new tag, target=upd_target, counter = all-ones if jump else weakly-taken (MSB=1, rest 0).
REQ-029 SHALL, on miss and not taken and not jump: leave the table unchanged.
REQ-030 SHALL give lookup no bypass: a same-cycle update to the looked-up index is visible only from the next cycle.
REQ-031 SHALL, on inv_all & en: clear all valid bits next edge; inv_all has priority over a same-cycle update (update discarded, counters still count it).
REQ-032 SHALL increment cnt_updates on every upd_valid & en; cnt_mispredicts on upd_valid & upd_mispredict & en; both wrap 0xFFFFFFFF -> 0.
REQ-033 SHALL ignore upd_mispredict, upd_taken, upd_jump, upd_target when upd_valid=0.

Reset
REQ-034 SHALL, on arst_n low, immediately clear all valid bits, set all counters to weakly-not-taken (MSB=0, rest 1), targets to 0, both perf counters to 0.
REQ-035 SHALL therefore drive pred_hit=0, pred_taken=0, pred_target=lookup_pc+4 during and after reset until the first allocation.
REQ-036 SHALL abort any in-flight update when reset asserts mid-cycle; no partial entry write survives.

Verification
REQ-037 SHALL cover: after reset, lookup_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104.
REQ-038 SHALL cover: update pc=0x100 taken target=0x200, next cycle lookup 0x100 -> hit=1, taken=1, target=0x200; lookup 0x140 (same index, ENTRIES=16, different tag) -> hit=0.
REQ-039 SHALL cover: after allocation, two not-taken updates at 0x100 -> counter 10->01->00, pred_taken=0, target=0x104; four taken updates -> counter saturates at 11, no wrap.
REQ-040 SHALL cover: jump update pc=0x80 target=0x400 on miss -> counter 11, one not-taken update -> still predicts taken.
REQ-041 SHALL cover: inv_all and update asserted same cycle -> all pred_hit=0 next cycle, cnt_updates incremented by 1.
REQ-042 SHALL cover: en=0 with upd_valid=1 -> table and counters unchanged; cnt_mispredicts preloaded to 0xFFFFFFFF by 2^32-1 mispredict updates wraps to 0 on the next one.
